// File: rtl/key_matrix_scan.sv
// key_matrix_scan
//
// Row-strobed key matrix scanner. One row is driven active at a time for
// CLOCK_DELAY clocks. At the end of each row dwell the synchronised column
// pins are sampled. Every key in that row is debounced and a debounced
// key-state vector is maintained. Committed state changes are reported as
// events over a valid/ready handshake.
//
// Optional feature macro: KEY_MATRIX_SCAN_RELEASE_EVENTS_EN
//   defined   : both presses and releases produce events.
//   undefined : only presses produce events. Releases update o_keys
//               silently, even while the event slot is busy.
//               o_event_pressed is tied to 1.
//
// Ports
//   clk             system clock
//   i_rst           synchronous, active-high reset
//   i_cols          raw asynchronous column pins
//   o_rows          registered row strobes
//                   (active level set by ROW_OUTPUT_ACTIVE_LOW)
//   o_keys          debounced key state; bit r*NUM_COLS+c is 1 when pressed
//   o_event_valid   an event is waiting to be taken
//   o_event_key     key index of the event, r*NUM_COLS+c
//   o_event_pressed 1 = press, 0 = release
//   i_event_ready   consumer takes the event when valid and ready are both high

module key_matrix_scan #(
  parameter int NUM_ROWS              = 4,
  parameter int NUM_ROWS_WIDTH        = 2,
  parameter int NUM_COLS              = 4,
  parameter int NUM_COLS_WIDTH        = 2,
  parameter int KEY_WIDTH             = 4,
  parameter int CLOCK_DELAY           = 1000,
  parameter int CLOCK_DELAY_WIDTH     = 10,
  parameter int DEBOUNCE_SCANS        = 4,
  parameter int DEBOUNCE_WIDTH        = 3,
  parameter int ROW_OUTPUT_ACTIVE_LOW = 1,
  parameter int COL_INPUT_ACTIVE_LOW  = 1
) (
  input  logic                          clk,
  input  logic                          i_rst,
  input  logic [NUM_COLS-1:0]           i_cols,
  output logic [NUM_ROWS-1:0]           o_rows,
  output logic [NUM_ROWS*NUM_COLS-1:0]  o_keys,
  output logic                          o_event_valid,
  output logic [KEY_WIDTH-1:0]          o_event_key,
  output logic                          o_event_pressed,
  input  logic                          i_event_ready
);

  localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;

  // Levels seen on the pins when nothing is driven or pressed.
  localparam logic [NUM_ROWS-1:0] ROW_IDLE =
    (ROW_OUTPUT_ACTIVE_LOW != 0) ? {NUM_ROWS{1'b1}} : {NUM_ROWS{1'b0}};
  localparam logic [NUM_COLS-1:0] COL_IDLE =
    (COL_INPUT_ACTIVE_LOW != 0) ? {NUM_COLS{1'b1}} : {NUM_COLS{1'b0}};

  localparam logic [CLOCK_DELAY_WIDTH-1:0] LAST_COUNT =
    CLOCK_DELAY_WIDTH'(CLOCK_DELAY - 1);
  localparam logic [NUM_ROWS_WIDTH-1:0] LAST_ROW =
    NUM_ROWS_WIDTH'(NUM_ROWS - 1);
  localparam logic [DEBOUNCE_WIDTH-1:0] DEB_LIMIT =
    DEBOUNCE_WIDTH'(DEBOUNCE_SCANS);

  // --------------------------------------------------------------------
  // Column synchroniser. Both stages reset to the idle level so that
  // reset release never looks like a key press.
  // --------------------------------------------------------------------
  logic [NUM_COLS-1:0] col_meta_reg;
  logic [NUM_COLS-1:0] col_sync_reg;
  logic [NUM_COLS-1:0] pressed_now;

  always_ff @(posedge clk) begin
    if (i_rst) begin
      col_meta_reg <= COL_IDLE;
      col_sync_reg <= COL_IDLE;
    end else begin
      col_meta_reg <= i_cols;
      col_sync_reg <= col_meta_reg;
    end
  end

  // Normalise so that 1 always means pressed.
  generate
    if (COL_INPUT_ACTIVE_LOW != 0) begin : g_col_low
      assign pressed_now = ~col_sync_reg;
    end else begin : g_col_high
      assign pressed_now = col_sync_reg;
    end
  endgenerate

  // --------------------------------------------------------------------
  // Row scan timing
  // --------------------------------------------------------------------
  logic [NUM_ROWS_WIDTH-1:0]    row_idx_reg;
  logic [NUM_ROWS_WIDTH-1:0]    row_idx_next;
  logic [CLOCK_DELAY_WIDTH-1:0] dwell_reg;
  logic [CLOCK_DELAY_WIDTH-1:0] dwell_next;
  logic [NUM_ROWS-1:0]          rows_reg;
  logic [NUM_ROWS-1:0]          rows_next;
  logic [NUM_ROWS-1:0]          row_onehot;
  logic                         sample_tick;

  always_comb begin
    sample_tick  = (dwell_reg == LAST_COUNT);
    dwell_next   = dwell_reg + CLOCK_DELAY_WIDTH'(1);
    row_idx_next = row_idx_reg;
    if (sample_tick) begin
      dwell_next   = '0;
      row_idx_next = (row_idx_reg == LAST_ROW) ? '0
                                               : row_idx_reg + NUM_ROWS_WIDTH'(1);
    end
  end

  // The strobe follows the row index by one clock. The old row therefore
  // stays on the pins through its sample cycle, and the new row appears
  // on the cycle after the sample.
  always_comb begin
    row_onehot = NUM_ROWS'(1) << row_idx_reg;
    rows_next  = (ROW_OUTPUT_ACTIVE_LOW != 0) ? ~row_onehot : row_onehot;
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      row_idx_reg <= '0;
      dwell_reg   <= '0;
      rows_reg    <= ROW_IDLE;
    end else begin
      row_idx_reg <= row_idx_next;
      dwell_reg   <= dwell_next;
      rows_reg    <= rows_next;
    end
  end

  // --------------------------------------------------------------------
  // Per-column debounce decision for the row being sampled
  // --------------------------------------------------------------------
  logic [NUM_KEYS-1:0]       keys_reg;
  logic [DEBOUNCE_WIDTH-1:0] cnt_reg [NUM_KEYS];

  logic [KEY_WIDTH-1:0]      key_idx [NUM_COLS];
  logic [DEBOUNCE_WIDTH-1:0] cnt_now [NUM_COLS];
  logic [DEBOUNCE_WIDTH-1:0] cnt_inc [NUM_COLS];
  logic [NUM_COLS-1:0]       key_now;
  logic [NUM_COLS-1:0]       differ;
  logic [NUM_COLS-1:0]       request;

  generate
    for (genvar gi = 0; gi < NUM_COLS; gi++) begin : g_col
      assign key_idx[gi] = KEY_WIDTH'(int'(row_idx_reg) * NUM_COLS + gi);
      assign key_now[gi] = keys_reg[key_idx[gi]];
      assign cnt_now[gi] = cnt_reg[key_idx[gi]];
      assign differ[gi]  = pressed_now[gi] ^ key_now[gi];
      // The counter saturates at the limit. A key that lost arbitration
      // therefore re-requests at its next differing sample.
      assign cnt_inc[gi] = (cnt_now[gi] >= DEB_LIMIT) ? DEB_LIMIT
                                                      : cnt_now[gi] + DEBOUNCE_WIDTH'(1);
      assign request[gi] = sample_tick & differ[gi] & (cnt_inc[gi] == DEB_LIMIT);
    end
  endgenerate

  // --------------------------------------------------------------------
  // Commit arbitration. Requests that produce an event compete for the
  // single event slot, and the lowest column wins. Commits that produce
  // no event (silent releases) need no slot, so they are never held back.
  // --------------------------------------------------------------------
  logic [NUM_COLS-1:0]       event_request;
  logic [NUM_COLS-1:0]       free_commit;
  logic [NUM_COLS-1:0]       grant;
  logic [NUM_COLS-1:0]       commit;
  logic [NUM_COLS_WIDTH-1:0] win_col;
  logic                      found;
  logic                      slot_free;
  logic                      load_event;
  logic                      event_valid_reg;
  logic [KEY_WIDTH-1:0]      event_key_reg;

`ifdef KEY_MATRIX_SCAN_RELEASE_EVENTS_EN
  assign event_request = request;
  assign free_commit   = '0;
`else
  assign event_request = request & pressed_now;
  assign free_commit   = request & ~pressed_now;
`endif

  assign slot_free = ~event_valid_reg | i_event_ready;

  always_comb begin
    grant   = '0;
    win_col = '0;
    found   = 1'b0;
    for (int c = 0; c < NUM_COLS; c++) begin
      if (event_request[c] && !found) begin
        grant[c] = 1'b1;
        win_col  = NUM_COLS_WIDTH'(c);
        found    = 1'b1;
      end
    end
    if (!slot_free) begin
      grant = '0;
    end
    commit     = grant | free_commit;
    load_event = |grant;
  end

  // --------------------------------------------------------------------
  // Debounced state and counters. Only keys of the sampled row change.
  // --------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (i_rst) begin
      keys_reg <= '0;
      for (int k = 0; k < NUM_KEYS; k++) begin
        cnt_reg[k] <= '0;
      end
    end else if (sample_tick) begin
      for (int c = 0; c < NUM_COLS; c++) begin
        if (!differ[c]) begin
          // A match also cancels a pending (saturated) request.
          cnt_reg[key_idx[c]] <= '0;
        end else if (commit[c]) begin
          cnt_reg[key_idx[c]]  <= '0;
          keys_reg[key_idx[c]] <= ~key_now[c];
        end else begin
          cnt_reg[key_idx[c]] <= cnt_inc[c];
        end
      end
    end
  end

  // --------------------------------------------------------------------
  // Event register. A grant is only issued when the slot is free, so a
  // load never overwrites an event that has not been taken.
  // --------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (i_rst) begin
      event_valid_reg <= 1'b0;
      event_key_reg   <= '0;
    end else if (load_event) begin
      event_valid_reg <= 1'b1;
      event_key_reg   <= key_idx[win_col];
    end else if (i_event_ready) begin
      event_valid_reg <= 1'b0;
    end
  end

`ifdef KEY_MATRIX_SCAN_RELEASE_EVENTS_EN
  logic event_pressed_reg;

  always_ff @(posedge clk) begin
    if (i_rst) begin
      event_pressed_reg <= 1'b0;
    end else if (load_event) begin
      event_pressed_reg <= pressed_now[win_col];
    end
  end

  assign o_event_pressed = event_pressed_reg;
`else
  assign o_event_pressed = 1'b1;
`endif

  assign o_rows        = rows_reg;
  assign o_keys        = keys_reg;
  assign o_event_valid = event_valid_reg;
  assign o_event_key   = event_key_reg;

endmodule

// File: tb/tb_key_matrix_scan.sv
// Self-checking bench for key_matrix_scan in its default build (release
// events disabled). A behavioural key matrix pulls a column low when the
// column's key is held and its row is strobed. The expected events go into
// a queue. A monitor takes each accepted event and compares it with the
// head of the queue.

module tb_key_matrix_scan;

  localparam int NR = 4;
  localparam int NC = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  cols;
  logic [3:0]  rows;
  logic [15:0] keys;
  logic        ev_valid;
  logic [3:0]  ev_key;
  logic        ev_pressed;
  logic        ready;
  logic [15:0] held;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0] key;
    logic       pressed;
  } ev_t;

  ev_t exp_q[$];

  always #5 clk = ~clk;

  key_matrix_scan #(
    .NUM_ROWS(4), .NUM_ROWS_WIDTH(2), .NUM_COLS(4), .NUM_COLS_WIDTH(2),
    .KEY_WIDTH(4), .CLOCK_DELAY(8), .CLOCK_DELAY_WIDTH(3),
    .DEBOUNCE_SCANS(3), .DEBOUNCE_WIDTH(3),
    .ROW_OUTPUT_ACTIVE_LOW(1), .COL_INPUT_ACTIVE_LOW(1)
  ) dut (
    .clk(clk),
    .i_rst(rst),
    .i_cols(cols),
    .o_rows(rows),
    .o_keys(keys),
    .o_event_valid(ev_valid),
    .o_event_key(ev_key),
    .o_event_pressed(ev_pressed),
    .i_event_ready(ready)
  );

  // Key matrix with pull-ups: a held key pulls its column low while its row is low.
  always_comb begin
    cols = 4'b1111;
    for (int r = 0; r < NR; r++) begin
      for (int c = 0; c < NC; c++) begin
        if (!rows[r] && held[r*NC+c]) cols[c] = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Returns at the negedge where row r has just become active. The
  // previous sample of row r-1 has then completed.
  task automatic wait_dwell(input int r);
    logic [3:0] pat;
    int n;
    pat = ~(4'b0001 << r);
    n = 0;
    while (rows == pat && n < 100) begin @(negedge clk); n++; end
    while (rows != pat && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL wait_row%0d: timeout, rows %b expected %b", r, rows, pat);
    end
  endtask

  // Monitor: inputs change on negedges, so look a little later.
  always @(negedge clk) begin
    ev_t e;
    #1;
    if (!rst && ev_valid && ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: got key %0d pressed %0b expected none",
                 ev_key, ev_pressed);
      end else begin
        e = exp_q.pop_front();
        $display("event accepted: key %0d pressed %0b (expected key %0d pressed %0b)",
                 ev_key, ev_pressed, e.key, e.pressed);
        check("event_key", 32'(ev_key), 32'(e.key));
        check("event_pressed", 32'(ev_pressed), 32'(e.pressed));
      end
    end
  end

  initial begin
    rst   = 1'b1;
    ready = 1'b1;
    held  = '0;

    // 1. Reset and idle scan timing
    repeat (3) @(negedge clk);
    check("reset_rows", 32'(rows), 32'h0000000F);
    check("reset_keys", 32'(keys), 32'h0);
    check("reset_valid", 32'(ev_valid), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("rows_first", 32'(rows), 32'b1110);
    repeat (7) @(negedge clk);
    check("rows_row0_end", 32'(rows), 32'b1110);
    @(negedge clk);
    check("rows_row1", 32'(rows), 32'b1101);
    repeat (23) @(negedge clk);
    check("rows_row3", 32'(rows), 32'b0111);
    @(negedge clk);
    check("rows_wrap", 32'(rows), 32'b1110);
    check("idle_keys", 32'(keys), 32'h0);
    check("idle_valid", 32'(ev_valid), 32'h0);

    // 2. Hold key 9 (row 2, col 1): commits on the third row-2 sample
    wait_dwell(0);
    held[9] = 1'b1;
    exp_q.push_back('{key: 4'd9, pressed: 1'b1});
    wait_dwell(3);
    wait_dwell(3);
    check("k9_after2", 32'(keys[9]), 32'h0);
    wait_dwell(3);
    check("k9_after3", 32'(keys[9]), 32'h1);
    check("k9_event_taken", 32'(exp_q.size()), 32'h0);
    held[9] = 1'b0;
    repeat (3) wait_dwell(3);
    check("k9_released", 32'(keys[9]), 32'h0);

    // 3. Bounce: two pressed samples, then one released sample, then two pressed again
    held[9] = 1'b1;
    repeat (2) wait_dwell(3);
    held[9] = 1'b0;
    wait_dwell(3);
    check("bounce_keys", 32'(keys[9]), 32'h0);
    held[9] = 1'b1;
    repeat (2) wait_dwell(3);
    held[9] = 1'b0;
    wait_dwell(3);
    check("bounce_cleared", 32'(keys[9]), 32'h0);
    check("bounce_no_event", 32'(ev_valid), 32'h0);

    // 4. Back-pressure: event 9 holds, key 3 waits saturated
    ready = 1'b0;
    held[9] = 1'b1;
    exp_q.push_back('{key: 4'd9, pressed: 1'b1});
    repeat (3) wait_dwell(3);
    held[3] = 1'b1;
    exp_q.push_back('{key: 4'd3, pressed: 1'b1});
    repeat (4) wait_dwell(3);
    check("stall_valid", 32'(ev_valid), 32'h1);
    check("stall_key", 32'(ev_key), 32'd9);
    check("stall_k3", 32'(keys[3]), 32'h0);
    check("stall_k9", 32'(keys[9]), 32'h1);
    ready = 1'b1;
    wait_dwell(1);
    check("k3_committed", 32'(keys[3]), 32'h1);
    check("stall_queue_empty", 32'(exp_q.size()), 32'h0);
    held = '0;
    repeat (4) wait_dwell(3);
    check("stall_released", 32'(keys), 32'h0);

    // 5. Keys 4 and 6 together: 4 first, 6 one full scan later
    held[4] = 1'b1;
    held[6] = 1'b1;
    exp_q.push_back('{key: 4'd4, pressed: 1'b1});
    exp_q.push_back('{key: 4'd6, pressed: 1'b1});
    repeat (3) wait_dwell(2);
    check("pair_k4", 32'(keys[4]), 32'h1);
    check("pair_k6_wait", 32'(keys[6]), 32'h0);
    wait_dwell(2);
    check("pair_k6", 32'(keys[6]), 32'h1);
    check("pair_queue_empty", 32'(exp_q.size()), 32'h0);
    held = '0;
    repeat (5) wait_dwell(2);
    check("pair_released", 32'(keys), 32'h0);

    // 7. Silent release of key 9 while the slot is busy
    wait_dwell(3);
    ready = 1'b0;
    held[9] = 1'b1;
    exp_q.push_back('{key: 4'd9, pressed: 1'b1});
    repeat (3) wait_dwell(3);
    check("rel_pressed", 32'(keys[9]), 32'h1);
    held[9] = 1'b0;
    repeat (2) wait_dwell(3);
    check("rel_after2", 32'(keys[9]), 32'h1);
    wait_dwell(3);
    check("rel_after3", 32'(keys[9]), 32'h0);
    check("rel_busy_valid", 32'(ev_valid), 32'h1);
    check("rel_busy_key", 32'(ev_key), 32'd9);
    ready = 1'b1;
    wait_dwell(3);
    check("rel_queue_empty", 32'(exp_q.size()), 32'h0);
    check("rel_no_release_event", 32'(ev_valid), 32'h0);

    // 6. Reset while an event is pending
    ready = 1'b0;
    held[3] = 1'b1;
    exp_q.push_back('{key: 4'd3, pressed: 1'b1});
    repeat (3) wait_dwell(1);
    check("pre_rst_valid", 32'(ev_valid), 32'h1);
    check("pre_rst_k3", 32'(keys[3]), 32'h1);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("mid_rst_valid", 32'(ev_valid), 32'h0);
    check("mid_rst_keys", 32'(keys), 32'h0);
    check("mid_rst_rows", 32'(rows), 32'h0000000F);
    held  = '0;
    rst   = 1'b0;
    ready = 1'b1;
    @(negedge clk);
    check("post_rst_rows", 32'(rows), 32'b1110);
    repeat (4) wait_dwell(1);
    check("post_rst_keys", 32'(keys), 32'h0);
    check("post_rst_valid", 32'(ev_valid), 32'h0);
    check("final_queue_empty", 32'(exp_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_matrix_scan.md
Name: key_matrix_scan

Overview:
- Input-side counterpart to the row-multiplexed LED matrix driver: a row-strobed key matrix scanner.
- Drives one row active at a time and samples the column inputs once per row dwell.
- Debounces each key and maintains a debounced key-state vector.
- Emits press/release events over a valid/ready handshake to a consumer such as a CPU register block or command FSM.

Parameters:
- NUM_ROWS, 4: rows scanned.
- NUM_ROWS_WIDTH, 2: width of the row index.
- NUM_COLS, 4: column inputs.
- NUM_COLS_WIDTH, 2: width of the column index.
- KEY_WIDTH, 4: event key index width; must satisfy 2^KEY_WIDTH >= NUM_ROWS*NUM_COLS.
- CLOCK_DELAY, 1000: clk cycles per row dwell; must be >= 4.
- CLOCK_DELAY_WIDTH, 10: width of the dwell counter.
- DEBOUNCE_SCANS, 4: consecutive differing samples required to commit a change; range 1..2^DEBOUNCE_WIDTH-1.
- DEBOUNCE_WIDTH, 3: width of each per-key debounce counter.
- ROW_OUTPUT_ACTIVE_LOW, 1: 1 = active row driven low.
- COL_INPUT_ACTIVE_LOW, 1: 1 = pressed key reads low (pull-ups).

Ports:
- clk  input  1  system clock.
- i_rst  input  1  synchronous, active-high reset.
- i_cols  input  NUM_COLS  raw asynchronous column pins.
- o_rows  output  NUM_ROWS  row strobes, polarity per ROW_OUTPUT_ACTIVE_LOW.
- o_keys  output  NUM_ROWS*NUM_COLS  debounced state; bit r*NUM_COLS+c, 1 = pressed.
- o_event_valid  output  1  event available.
- o_event_key  output  KEY_WIDTH  key index, r*NUM_COLS+c.
- o_event_pressed  output  1  1 = press, 0 = release.
- i_event_ready  input  1  consumer accepts the event when valid and ready are both high.

Behaviour:
- Reset (i_rst high at a clk edge):
  - Row index 0, dwell counter 0, all debounce counters 0, o_keys all 0.
  - o_event_valid 0; o_event_key and o_event_pressed 0.
  - o_rows registered, all rows inactive.
  - Both column synchroniser stages loaded with the "not pressed" level.
- Scan:
  - From the first cycle after reset release, o_rows asserts the current row only (registered, one-hot).
  - Dwell counter runs 0..CLOCK_DELAY-1.
  - At count CLOCK_DELAY-1: take the sample, the row index advances (NUM_ROWS-1 wraps to 0) and the counter returns to 0.
  - The new row appears on o_rows the next cycle.
  - Full scan period = NUM_ROWS*CLOCK_DELAY cycles.
- Sample:
  - i_cols passes through a 2-flop synchroniser and is normalised to pressed = 1.
  - The synchronised value at count CLOCK_DELAY-1 is the sample for the current row; the rows not being scanned are untouched.
- Debounce, per key in the sampled row:
  - Sample equals o_keys bit: counter cleared to 0.
  - Sample differs: counter increments, saturating at DEBOUNCE_SCANS.
  - When the counter reaches DEBOUNCE_SCANS, a commit is requested.
- Commit:
  - Toggles the o_keys bit, clears that key's counter, and loads the event register with valid=1, key and direction.
  - Allowed only if the event slot is free: o_event_valid=0, or o_event_valid=1 and i_event_ready=1 in the same cycle.
  - At most one commit per sample; the lowest column index wins.
  - Other requesting keys keep saturated counters and retry at their row's next sample. No event is ever lost.
  - A saturated key whose sample returns to match o_keys clears its counter and cancels its request.
- Handshake:
  - o_event_valid, o_event_key and o_event_pressed hold stable until accepted.
  - Acceptance with no new commit clears o_event_valid the next cycle.
  - Acceptance plus a commit in the same cycle loads the new event back-to-back.
- Reset mid-scan or mid-event: all state returns to reset values immediately; a pending event is discarded.

Optional Feature:
- Macro: KEY_MATRIX_SCAN_RELEASE_EVENTS_EN.
- Defined: both presses and releases generate events, as described in Behaviour.
- Undefined:
  - Only presses generate events and need a free slot.
  - Release commits clear the o_keys bit and counter without touching the event register, even while it is busy.
  - o_event_pressed is tied to 1.

Test Plan (NUM_ROWS=4, NUM_COLS=4, CLOCK_DELAY=8, DEBOUNCE_SCANS=3, active-low rows and columns):
1. Release reset, no keys held:
   - o_rows=4'b1111 during reset, then 4'b1110 on the first cycle after release.
   - 4'b1101 after 8 cycles, back to 4'b1110 after 32 cycles.
   - o_keys=0, no event.
2. Hold key r2,c1 (i_cols[1]=0 while row 2 active), i_event_ready=1:
   - Commit at the third row-2 sample.
   - o_keys[9]=1; one pulse of o_event_valid with key=9, pressed=1.
3. Bounce key r2,c1 pressed for 2 row-2 samples, then released:
   - No event, o_keys[9] stays 0.
   - Counter cleared (verify with 2 further pressed samples: still no event).
4. i_event_ready=0; press key 9, then key 3:
   - Event 9 holds stable; o_keys[3] stays 0.
   - Raise ready: event 9 accepted; event 3 commits at the next row-0 sample.
5. Press keys r1,c0 and r1,c2 simultaneously:
   - Event key 4 first; key 6 commits one scan later (32 cycles).
6. Assert i_rst while o_event_valid=1 with o_keys nonzero:
   - Next cycle o_event_valid=0, o_keys=0, o_rows=4'b1111.
7. Macro undefined, release key 9 while the event slot is busy:
   - o_keys[9] clears after 3 samples; no release event.
